// File: rtl/regfile_status_pkg.sv
// Shared definitions for the writeback/register-file slice.
// Holds the processor status codes, the register IDs (including the
// "no register" ID RNONE and the stack pointer RSP) and the storage
// geometry. Anything that decodes stat or register IDs imports this
// package, so every block agrees on a single encoding.
package regfile_status_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned NREGS  = 15;

  // Processor status codes
  localparam logic [3:0] SAOK = 4'h1;
  localparam logic [3:0] SHLT = 4'h2;
  localparam logic [3:0] SADR = 4'h3;
  localparam logic [3:0] SINS = 4'h4;

  // Register IDs
  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/regfile_array.sv
// 15 x 64-bit register storage with two write ports and two read ports.
// Ports:
//   clk_i, rst_n_i           clock, async active-low reset (clears storage)
//   we_e_i, dstE_i, valE_i   E write port
//   we_m_i, dstM_i, valM_i   M write port; wins when both target one register
//   srcA_i/srcB_i            read IDs
//   valA_o/valB_o            combinational read data from stored state;
//                            ID RNONE (and any ID without storage) reads 0
module regfile_array
  import regfile_status_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              we_e_i,
  input  logic [3:0]        dstE_i,
  input  logic [DATA_W-1:0] valE_i,
  input  logic              we_m_i,
  input  logic [3:0]        dstM_i,
  input  logic [DATA_W-1:0] valM_i,
  input  logic [3:0]        srcA_i,
  input  logic [3:0]        srcB_i,
  output logic [DATA_W-1:0] valA_o,
  output logic [DATA_W-1:0] valB_o
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        // M is checked first so it takes priority on a shared destination.
        if (we_m_i && dstM_i == 4'(i))
          regs[i] <= valM_i;
        else if (we_e_i && dstE_i == 4'(i))
          regs[i] <= valE_i;
      end
    end
  end

  // Decoding by loop keeps ID 15 out of the array entirely: it matches no
  // entry and therefore returns zero, with no out-of-range index.
  function automatic logic [DATA_W-1:0] read_reg(input logic [3:0] id);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NREGS; i++)
      if (id == 4'(i)) v = regs[i];
    return v;
  endfunction

  always_comb begin
    valA_o = read_reg(srcA_i);
    valB_o = read_reg(srcB_i);
  end

endmodule

// File: rtl/regfile_status.sv
// Writeback commit control: register file, processor status FSM and a
// retired-instruction counter.
// Ports:
//   clk_i, rst_n_i          clock, async active-low reset
//   wb_valid_i              an instruction is presented this cycle
//   stat_i                  its status code
//   dstE_i/valE_i           E write port (RNONE = no write)
//   dstM_i/valM_i           M write port (RNONE = no write), wins on collision
//   srcA_i/srcB_i           read IDs; valA_o/valB_o combinational read data
//   cpu_stat_o              registered processor status (SAOK while running)
//   running_o               high only while the FSM is in RUN
//   retired_o               committed-instruction count, wraps
//   state_o                 FSM state for observation (0 RUN, 1 HALT, 2 ERR)
// Handshake: an instruction is taken when wb_valid_i is high on a rising
// edge; there is no back-pressure. It commits only if the FSM is in RUN and
// its status is SAOK; any other status in RUN ends execution instead.
module regfile_status
  import regfile_status_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wb_valid_i,
  input  logic [3:0]        stat_i,
  input  logic [3:0]        dstE_i,
  input  logic [63:0]       valE_i,
  input  logic [3:0]        dstM_i,
  input  logic [63:0]       valM_i,
  input  logic [3:0]        srcA_i,
  input  logic [3:0]        srcB_i,
  output logic [63:0]       valA_o,
  output logic [63:0]       valB_o,
  output logic [3:0]        cpu_stat_o,
  output logic              running_o,
  output logic [CNT_W-1:0]  retired_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  state_t state;
  logic   commit;

  assign commit = wb_valid_i && (state == ST_RUN) && (stat_i == SAOK);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= ST_RUN;
      cpu_stat_o <= SAOK;
      retired_o  <= '0;
    end else if (wb_valid_i && state == ST_RUN) begin
      case (stat_i)
        SAOK: retired_o <= retired_o + 1'b1;
        SHLT: begin
          state      <= ST_HALT;
          cpu_stat_o <= SHLT;
        end
        SADR: begin
          state      <= ST_ERR;
          cpu_stat_o <= SADR;
        end
        // SINS and every undefined code end up as an instruction error.
        default: begin
          state      <= ST_ERR;
          cpu_stat_o <= SINS;
        end
      endcase
    end
    // HALT and ERR have no exits: only reset leaves them.
  end

  assign running_o = (state == ST_RUN);
  assign state_o   = state;

  regfile_array u_array (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .we_e_i  (commit && dstE_i != RNONE),
    .dstE_i  (dstE_i),
    .valE_i  (valE_i),
    .we_m_i  (commit && dstM_i != RNONE),
    .dstM_i  (dstM_i),
    .valM_i  (valM_i),
    .srcA_i  (srcA_i),
    .srcB_i  (srcB_i),
    .valA_o  (valA_o),
    .valB_o  (valB_o)
  );

endmodule

// File: tb/tb_regfile_status.sv
module tb_regfile_status;

  localparam int CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_n_i = 1'b1;
  logic             wb_valid_i = 1'b0;
  logic [3:0]       stat_i = 4'h1;
  logic [3:0]       dstE_i = 4'hF;
  logic [63:0]      valE_i = '0;
  logic [3:0]       dstM_i = 4'hF;
  logic [63:0]      valM_i = '0;
  logic [3:0]       srcA_i = 4'h0;
  logic [3:0]       srcB_i = 4'h0;
  logic [63:0]      valA_o, valB_o;
  logic [3:0]       cpu_stat_o;
  logic             running_o;
  logic [CNT_W-1:0] retired_o;
  logic [1:0]       state_o;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  regfile_status #(.CNT_W(CNT_W)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .wb_valid_i (wb_valid_i),
    .stat_i     (stat_i),
    .dstE_i     (dstE_i),
    .valE_i     (valE_i),
    .dstM_i     (dstM_i),
    .valM_i     (valM_i),
    .srcA_i     (srcA_i),
    .srcB_i     (srcB_i),
    .valA_o     (valA_o),
    .valB_o     (valB_o),
    .cpu_stat_o (cpu_stat_o),
    .running_o  (running_o),
    .retired_o  (retired_o),
    .state_o    (state_o)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Present one instruction, take one rising edge, then drop valid.
  task automatic issue(input logic [3:0] st, input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm);
    wb_valid_i = 1'b1;
    stat_i = st; dstE_i = de; valE_i = ve; dstM_i = dm; valM_i = vm;
    @(posedge clk_i); #1;
    wb_valid_i = 1'b0;
    stat_i = 4'h0; dstE_i = 4'h5; valE_i = 64'hDEAD; dstM_i = 4'h6; valM_i = 64'hBEEF;
  endtask

  task automatic idle_cycle();
    @(posedge clk_i); #1;
  endtask

  task automatic read2(input logic [3:0] a, input logic [3:0] b);
    srcA_i = a; srcB_i = b; #1;
  endtask

  initial begin
    // ---------------- reset ----------------
    #1 rst_n_i = 1'b0;
    #1;
    check("reset_stat", 64'(cpu_stat_o), 64'h1);
    check("reset_running", 64'(running_o), 64'h1);
    check("reset_retired", 64'(retired_o), 64'h0);
    check("reset_state", 64'(state_o), 64'h0);
    read2(4'h0, 4'hE);
    check("reset_r0", valA_o, 64'h0);
    check("reset_r14", valB_o, 64'h0);
    idle_cycle();
    rst_n_i = 1'b1;

    // ---------------- basic two-port write ----------------
    wb_valid_i = 1'b1; stat_i = 4'h1;
    dstE_i = 4'h0; valE_i = 64'h5; dstM_i = 4'h3; valM_i = 64'h9;
    read2(4'h0, 4'h3);
    check("no_bypass_a", valA_o, 64'h0);
    check("no_bypass_b", valB_o, 64'h0);
    @(posedge clk_i); #1;
    wb_valid_i = 1'b0;
    read2(4'h0, 4'h3);
    check("wr_r0", valA_o, 64'h5);
    check("wr_r3", valB_o, 64'h9);
    check("retired_1", 64'(retired_o), 64'h1);

    // ---------------- M priority on collision ----------------
    issue(4'h1, 4'h4, 64'h100, 4'h4, 64'h200);
    read2(4'h4, 4'h0);
    check("m_priority", valA_o, 64'h200);
    check("retired_2", 64'(retired_o), 64'h2);

    // ---------------- valid low changes nothing ----------------
    wb_valid_i = 1'b0; stat_i = 4'h1; dstE_i = 4'h5; valE_i = 64'h77; dstM_i = 4'h5; valM_i = 64'h78;
    idle_cycle();
    read2(4'h5, 4'h4);
    check("idle_r5", valA_o, 64'h0);
    check("idle_r4", valB_o, 64'h200);
    check("idle_retired", 64'(retired_o), 64'h2);

    // ---------------- RNONE on E, write on M ----------------
    issue(4'h1, 4'hF, 64'h11, 4'h6, 64'h66);
    read2(4'h6, 4'hF);
    check("rnone_r6", valA_o, 64'h66);
    check("rnone_read", valB_o, 64'h0);
    check("retired_3", 64'(retired_o), 64'h3);

    // ---------------- counter wrap (CNT_W=4) ----------------
    for (int i = 0; i < 12; i++) issue(4'h1, 4'h7, 64'(i + 1), 4'hF, 64'h0);
    check("retired_max", 64'(retired_o), 64'hF);
    read2(4'h7, 4'h0);
    check("r7_after_loop", valA_o, 64'hC);
    issue(4'h1, 4'hE, 64'hE0E0, 4'hF, 64'h0);
    check("retired_wrap", 64'(retired_o), 64'h0);
    read2(4'hE, 4'h0);
    check("r14", valA_o, 64'hE0E0);

    // ---------------- HALT ----------------
    issue(4'h2, 4'h2, 64'hAA, 4'hF, 64'h0);
    read2(4'h2, 4'h0);
    check("halt_r2", valA_o, 64'h0);
    check("halt_stat", 64'(cpu_stat_o), 64'h2);
    check("halt_running", 64'(running_o), 64'h0);
    check("halt_state", 64'(state_o), 64'h1);
    check("halt_retired", 64'(retired_o), 64'h0);
    issue(4'h1, 4'h2, 64'hAB, 4'h2, 64'hAC);
    read2(4'h2, 4'h0);
    check("halt_abs_r2", valA_o, 64'h0);
    check("halt_abs_retired", 64'(retired_o), 64'h0);
    issue(4'h3, 4'hF, 64'h0, 4'hF, 64'h0);
    check("halt_abs_stat", 64'(cpu_stat_o), 64'h2);

    // ---------------- reset, then ERR ----------------
    rst_n_i = 1'b0; #1;
    check("rst2_stat", 64'(cpu_stat_o), 64'h1);
    idle_cycle();
    rst_n_i = 1'b1;
    issue(4'h3, 4'h2, 64'hBB, 4'h1, 64'hBC);
    read2(4'h2, 4'h1);
    check("err_r2", valA_o, 64'h0);
    check("err_r1", valB_o, 64'h0);
    check("err_stat", 64'(cpu_stat_o), 64'h3);
    check("err_state", 64'(state_o), 64'h2);
    check("err_running", 64'(running_o), 64'h0);
    issue(4'h4, 4'h2, 64'hCC, 4'hF, 64'h0);
    check("err_sticky", 64'(cpu_stat_o), 64'h3);
    issue(4'h1, 4'h2, 64'hDD, 4'hF, 64'h0);
    read2(4'h2, 4'h0);
    check("err_abs_r2", valA_o, 64'h0);
    check("err_abs_retired", 64'(retired_o), 64'h0);

    // ---------------- undefined code treated as SINS ----------------
    rst_n_i = 1'b0; #1;
    idle_cycle();
    rst_n_i = 1'b1;
    issue(4'h1, 4'h0, 64'h5, 4'hF, 64'h0);
    issue(4'h9, 4'h0, 64'h99, 4'hF, 64'h0);
    check("undef_stat", 64'(cpu_stat_o), 64'h4);
    read2(4'h0, 4'h0);
    check("undef_r0", valA_o, 64'h5);
    check("undef_retired", 64'(retired_o), 64'h1);

    // ---------------- async reset between edges in ERR ----------------
    @(posedge clk_i); #3;
    rst_n_i = 1'b0; #1;
    check("async_stat", 64'(cpu_stat_o), 64'h1);
    check("async_running", 64'(running_o), 64'h1);
    check("async_retired", 64'(retired_o), 64'h0);
    read2(4'hF, 4'h0);
    check("async_r15", valA_o, 64'h0);
    check("async_r0", valB_o, 64'h0);

    // In-flight write during reset is dropped.
    wb_valid_i = 1'b1; stat_i = 4'h1; dstE_i = 4'h1; valE_i = 64'h123; dstM_i = 4'hF;
    idle_cycle();
    wb_valid_i = 1'b0;
    read2(4'h1, 4'h0);
    check("rst_drop_r1", valA_o, 64'h0);
    check("rst_drop_retired", 64'(retired_o), 64'h0);

    // First commit on the first edge after release.
    rst_n_i = 1'b1;
    issue(4'h1, 4'h8, 64'h88, 4'hF, 64'h0);
    read2(4'h8, 4'h0);
    check("first_commit_r8", valA_o, 64'h88);
    check("first_commit_retired", 64'(retired_o), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
